// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: shared defaults, address-region type and word-index decoder for dmem_io_ctrl
package dmem_io_pkg;

    localparam int NUM_BTN_DEF         = 4;
    localparam int NUM_SW_DEF          = 2;
    localparam int RAM_AW_DEF          = 17;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        REG_BTN,
        REG_SW,
        REG_RAM
    } region_e;

    // Buttons occupy the lowest words, switches follow, everything above is RAM
    function automatic region_e word_region(input logic [29:0] w, input int nb, input int ns);
        return (w < 30'(nb)) ? REG_BTN : (w < 30'(nb + ns)) ? REG_SW : REG_RAM;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one push-button channel (2-flop synchroniser, optional debounce, sticky
// rising-edge latch with CPU load). Debounce filtering is built only when DMEM_DEBOUNCE_EN
// is defined; otherwise the debounced state follows the synchronised input directly.
module btn_debounce
    import dmem_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic wr_i,
    input  logic wd_i,
    output logic latch_o
);

    logic [1:0] sync_q;
    logic       deb_d, deb_q;
    logic       latch_d, latch_q;

`ifdef DMEM_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          diff;

    // Count consecutive cycles of disagreement; any agreement restarts the count
    always_comb begin
        diff  = sync_q[1] != deb_q;
        deb_d = (diff && cnt_q == LAST) ? sync_q[1] : deb_q;
        cnt_d = (!diff || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Debounce counter, cleared by reset so a partial count is discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int cycles_unused = DEBOUNCE_CYCLES;

    assign deb_d = sync_q[1];
`endif

    // A debounced rising edge sets the latch and overrides a simultaneous CPU load
    always_comb latch_d = (deb_d & ~deb_q) | (wr_i ? wd_i : latch_q);

    // Synchroniser, debounced state and sticky latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            deb_q   <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            deb_q   <= deb_d;
            latch_q <= latch_d;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/dmem_io_ctrl.sv
// dmem_io_ctrl: CPU data memory with memory-mapped button latches and switches, plus a
// read-only video port. Optional button debouncing is enabled by defining DMEM_DEBOUNCE_EN.
module dmem_io_ctrl
    import dmem_io_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int NUM_SW          = NUM_SW_DEF,
    parameter int RAM_AW          = RAM_AW_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [31:0]       a,
    input  logic [31:0]       wd,
    input  logic [31:0]       va,
    input  logic [NUM_BTN-1:0] button,
    input  logic [NUM_SW-1:0] switch,
    output logic [31:0]       rd,
    output logic [31:0]       pixel
);

    localparam int IO_WORDS = NUM_BTN + NUM_SW;
    localparam int IW       = (IO_WORDS > 1) ? $clog2(IO_WORDS) : 1;

    logic [31:0]        mem [2**RAM_AW];
    logic [NUM_BTN-1:0] btn_latch;
    logic [NUM_SW-1:0]  sw_s1_q, sw_s2_q;
    logic [RAM_AW-1:0]  ram_idx;
    logic [2**IW-1:0]   io_vec;
    region_e            region_d, region_q;
    logic               io_d, io_q;
    logic [31:0]        ram_rd_q, pix_rd_q;
    logic               pix_vld_q;
    logic               unused_bits;

    assign ram_idx     = a[RAM_AW+1:2];
    assign region_d    = word_region(a[31:2], NUM_BTN, NUM_SW);
    assign unused_bits = &{1'b0, a[1:0], va[31:RAM_AW]};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (button[i]),
            .wr_i   (we && a[31:2] == 30'(i)),
            .wd_i   (wd[0]),
            .latch_o(btn_latch[i])
        );
    end

    // Flatten IO words into one bit vector so the IO read is a single index
    always_comb begin
        io_vec               = '0;
        io_vec[IO_WORDS-1:0] = {sw_s2_q, btn_latch};
        io_d                 = io_vec[a[IW+1:2]];
    end

    // Switch synchroniser and registered read-select/IO-data path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            region_q  <= REG_BTN;
            io_q      <= 1'b0;
            pix_vld_q <= 1'b0;
        end else begin
            sw_s1_q   <= switch;
            sw_s2_q   <= sw_s1_q;
            region_q  <= region_d;
            io_q      <= io_d;
            pix_vld_q <= 1'b1;
        end
    end

    // RAM with registered read ports; left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we && region_d == REG_RAM) mem[ram_idx] <= wd;
        ram_rd_q <= mem[ram_idx];
        pix_rd_q <= mem[va[RAM_AW-1:0]];
    end

    assign rd    = (region_q == REG_RAM) ? ram_rd_q : {31'b0, io_q};
    assign pixel = pix_vld_q ? pix_rd_q : '0;

endmodule

// File: doc/dmem_io_ctrl.md
DMEM_IO_CTRL -- requirements
Module: dmem_io_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_BTN, 4, number of push-button channels.
REQ-002 NUM_SW, 2, number of slide-switch channels.
REQ-003 RAM_AW, 17, data RAM word-address width (2**RAM_AW words of 32 bits).
REQ-004 DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button change (>=1).
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock; all logic on its rising edge.
REQ-006 reset, in, 1, asynchronous active-high reset.
REQ-007 we, in, 1, CPU write enable.
REQ-008 a, in, 32, CPU byte address; word index = a[31:2].
REQ-009 wd, in, 32, CPU write data.
REQ-010 va, in, 32, video word address; only va[RAM_AW-1:0] is used.
REQ-011 button, in, NUM_BTN, raw asynchronous push-buttons.
REQ-012 switch, in, NUM_SW, raw asynchronous switches.
REQ-013 rd, out, 32, CPU read data.
REQ-014 pixel, out, 32, video read data.

Function
REQ-015 Address map SHALL be: word W < NUM_BTN is the button latch W; NUM_BTN <= W < IO_WORDS (= NUM_BTN+NUM_SW) is switch W-NUM_BTN; W >= IO_WORDS is RAM word a[RAM_AW+1:2].
REQ-016 Every raw button and switch input SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 Each button SHALL have a debounced state that changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality resets that channel's counter to 0.
REQ-018 A 0->1 transition of a debounced button state SHALL set that channel's sticky latch on the same edge.
REQ-019 A CPU write (we=1) to button word W SHALL load latch W with wd[0].
REQ-020 A simultaneous debounced rising edge and CPU write on the same latch SHALL leave the latch set (edge wins).
REQ-021 A button latch SHALL read as {31'b0, latch}; a switch word SHALL read as {31'b0, synchronised switch}.
REQ-022 Writes to switch words SHALL be ignored; RAM SHALL be written only when we=1 and W >= IO_WORDS.
REQ-023 RAM addresses SHALL wrap modulo 2**RAM_AW; upper address bits are ignored for RAM.
REQ-024 rd SHALL be registered with 1-cycle latency for all regions; the select SHALL be the registered region of the previous-cycle address.
REQ-025 A RAM read of the word being written in the same cycle SHALL return the old data (read-before-write).
REQ-026 pixel SHALL return RAM[va] with 1-cycle latency from a read-only second port; it never writes.

Reset
REQ-027 reset SHALL asynchronously clear synchroniser flops, debounced states, debounce counters, button latches, rd and pixel to 0.
REQ-028 RAM contents SHALL NOT be reset; a reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-029 With DMEM_DEBOUNCE_EN defined, REQ-017 SHALL apply.
REQ-030 Without DMEM_DEBOUNCE_EN, the debounced state SHALL equal the synchronised input, no counters SHALL be instantiated, and DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-031 Package dmem_io_pkg SHALL hold default parameter values, region enum (REG_BTN, REG_SW, REG_RAM) and the word-index-to-region function.
REQ-032 Sub-module btn_debounce SHALL implement one synchroniser+debounce+edge channel, instantiated NUM_BTN times by generate.

Verification
REQ-033 After reset, read words 0..5 -> rd=0 for buttons; switch=2'b11 -> words 4,5 read 1 after 3 cycles.
REQ-034 DMEM_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: pulse button[1] high for 3 cycles -> word 1 stays 0; hold 8 cycles -> word 1 reads 1 and stays 1 after release.
REQ-035 Write wd=0 to a=4 on the same edge as a debounced rising edge on button[1] -> word 1 reads 1; a later write wd=0 -> reads 0.
REQ-036 Write 255 to a=24, 128 to a=28, 511 to a=32; read back a=24,28,32 -> rd=255,128,511 one cycle after each address.
REQ-037 Write 0xDEADBEEF to a=24 and read a=24 in the same cycle -> rd shows old value; next read shows 0xDEADBEEF; va=6 -> pixel=0xDEADBEEF one cycle later.
REQ-038 Write wd=1 to a=16 (switch word) -> rd at a=16 still reflects switch[0]; RAM word 4 unchanged.
